// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper_if
// Brief    : Stimulus/capture bundle between a truth-table sweeper and the
//            combinational block under test plus its status consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
);
    localparam int c_rows = 1 << N_IN;

    logic              start;
    logic [N_IN-1:0]   in_vec;
    logic              z_in;
    logic              busy;
    logic              row_valid;
    logic [N_IN-1:0]   row_idx;
    logic              row_z;
    logic [c_rows-1:0] table_out;
    logic              done;
    logic              pass;

    modport master (
        input  start, z_in,
        output in_vec, busy, row_valid, row_idx, row_z, table_out, done, pass
    );

    modport slave (
        output start, z_in,
        input  in_vec, busy, row_valid, row_idx, row_z, table_out, done, pass
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Walks all 2^N_IN input combinations, holds each HOLD cycles,
//            samples z, builds the truth table and compares it with EXPECT.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int                   N_IN   = 2,
    parameter int                   HOLD   = 4,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0001
) (
    input  wire logic             clk,
    input  wire logic             reset,
    truth_table_sweeper_if.master sw
);
    localparam int c_rows   = 1 << N_IN;
    localparam int c_hold_w = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N_IN-1:0]     c_last_idx  = '1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state,     w_state;
    logic [N_IN-1:0]     r_idx,       w_idx;
    logic [c_hold_w-1:0] r_hold,      w_hold;
    logic [c_rows-1:0]   r_table,     w_table;
    logic                r_busy,      w_busy;
    logic                r_row_valid, w_row_valid;
    logic [N_IN-1:0]     r_row_idx,   w_row_idx;
    logic                r_row_z,     w_row_z;
    logic                r_done,      w_done;
    logic                r_pass,      w_pass;
    logic [c_rows-1:0]   w_table_sampled;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_hold      <= '0;
            r_table     <= '0;
            r_busy      <= 1'b0;
            r_row_valid <= 1'b0;
            r_row_idx   <= '0;
            r_row_z     <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_hold      <= w_hold;
            r_table     <= w_table;
            r_busy      <= w_busy;
            r_row_valid <= w_row_valid;
            r_row_idx   <= w_row_idx;
            r_row_z     <= w_row_z;
            r_done      <= w_done;
            r_pass      <= w_pass;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_hold      = r_hold;
        w_table     = r_table;
        w_busy      = r_busy;
        w_row_valid = 1'b0;
        w_row_idx   = r_row_idx;
        w_row_z     = r_row_z;
        w_done      = 1'b0;
        w_pass      = r_pass;

        // Table as it will look once the current row is captured; pass is
        // judged on this so the final row is included in the same edge.
        w_table_sampled        = r_table;
        w_table_sampled[r_idx] = sw.z_in;

        case (r_state)
            S_IDLE: begin
                if (sw.start) begin
                    w_state = S_RUN;
                    w_idx   = '0;
                    w_hold  = '0;
                    w_table = '0;
                    w_pass  = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_RUN: begin
                if (r_hold != c_hold_last) begin
                    w_hold = r_hold + 1'b1;
                end else begin
                    w_table     = w_table_sampled;
                    w_row_valid = 1'b1;
                    w_row_idx   = r_idx;
                    w_row_z     = sw.z_in;
                    if (r_idx != c_last_idx) begin
                        w_idx  = r_idx + 1'b1;
                        w_hold = '0;
                    end else begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_table_sampled == EXPECT);
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // in_vec is the row index itself; it stays on the last row after the sweep.
    assign sw.in_vec    = r_idx;
    assign sw.busy      = r_busy;
    assign sw.row_valid = r_row_valid;
    assign sw.row_idx   = r_row_idx;
    assign sw.row_z     = r_row_z;
    assign sw.table_out = r_table;
    assign sw.done      = r_done;
    assign sw.pass      = r_pass;
endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Self-checking bench for truth_table_sweeper: two configurations,
//            elapsed-time reference model, directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;
    localparam int         NA = 2;
    localparam int         HA = 4;
    localparam logic [3:0] EA = 4'b0001;
    localparam int         NB = 3;
    localparam int         HB = 1;
    localparam logic [7:0] EB = 8'h80;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    // Function under test per instance: 0 = (x'.y)'.(x'.y'), 1 = x^y, 2 = AND3, 3 = random table
    int          mode [2] = '{0, 2};
    logic [63:0] rtab [2] = '{64'd0, 64'd0};

    int          nn [2] = '{NA, NB};
    int          hh [2] = '{HA, HB};
    logic [63:0] ee [2] = '{64'(EA), 64'(EB)};

    int          m_phase [2] = '{0, 0};
    int          m_t     [2] = '{0, 0};
    int          m_invec [2] = '{0, 0};
    int          m_ridx  [2] = '{0, 0};
    logic [63:0] m_f     [2] = '{64'd0, 64'd0};
    logic [63:0] m_table [2] = '{64'd0, 64'd0};
    logic        m_rv    [2] = '{1'b0, 1'b0};
    logic        m_rz    [2] = '{1'b0, 1'b0};
    logic        m_pass  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(NA)) if_a ();
    truth_table_sweeper_if #(.N_IN(NB)) if_b ();

    truth_table_sweeper #(.N_IN(NA), .HOLD(HA), .EXPECT(EA)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .sw    (if_a)
    );
    truth_table_sweeper #(.N_IN(NB), .HOLD(HB), .EXPECT(EB)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .sw    (if_b)
    );

    function automatic logic zfun(input int md, input logic [63:0] tb_tab, input logic [5:0] v);
        case (md)
            0:       zfun = ~(~v[1] & v[0]) & (~v[1] & ~v[0]);
            1:       zfun = v[1] ^ v[0];
            2:       zfun = &v[2:0];
            default: zfun = tb_tab[v];
        endcase
    endfunction

    assign if_a.z_in = zfun(mode[0], rtab[0], 6'(if_a.in_vec));
    assign if_b.z_in = zfun(mode[1], rtab[1], 6'(if_b.in_vec));

    function automatic logic bsy(input int i);  return (i == 0) ? if_a.busy      : if_b.busy;      endfunction
    function automatic logic rv(input int i);   return (i == 0) ? if_a.row_valid : if_b.row_valid; endfunction
    function automatic logic rz(input int i);   return (i == 0) ? if_a.row_z     : if_b.row_z;     endfunction
    function automatic logic dn(input int i);   return (i == 0) ? if_a.done      : if_b.done;      endfunction
    function automatic logic pas(input int i);  return (i == 0) ? if_a.pass      : if_b.pass;      endfunction
    function automatic logic [63:0] ridx(input int i);
        return (i == 0) ? 64'(if_a.row_idx) : 64'(if_b.row_idx);
    endfunction
    function automatic logic [63:0] ivec(input int i);
        return (i == 0) ? 64'(if_a.in_vec) : 64'(if_b.in_vec);
    endfunction
    function automatic logic [63:0] tab(input int i);
        return (i == 0) ? 64'(if_a.table_out) : 64'(if_b.table_out);
    endfunction

    task automatic set_start(input int i, input logic v);
        if (i == 0) if_a.start = v; else if_b.start = v;
    endtask
    task automatic set_rst(input int i, input logic v);
        if (i == 0) rst_a = v; else rst_b = v;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model driven by elapsed edges t since start acceptance:
    // row k is sampled when t == (k+1)*HOLD, sweep ends at t == 2^N*HOLD.
    task automatic model_step(input int i, input logic r, input logic s);
        int len;
        int row;
        len      = (1 << nn[i]) * hh[i];
        m_rv[i]  = 1'b0;
        if (r) begin
            m_phase[i] = 0;  m_t[i] = 0;     m_invec[i] = 0;  m_ridx[i] = 0;
            m_rz[i]    = 0;  m_table[i] = '0; m_pass[i] = 1'b0;
        end else if (m_phase[i] == 0) begin
            if (s) begin
                m_phase[i] = 1;  m_t[i] = 0;  m_invec[i] = 0;
                m_table[i] = '0; m_pass[i] = 1'b0;
                m_f[i]     = '0;
                for (int v = 0; v < (1 << nn[i]); v++)
                    m_f[i][v] = zfun(mode[i], rtab[i], 6'(v));
            end
        end else if (m_phase[i] == 1) begin
            m_t[i]++;
            if (m_t[i] % hh[i] == 0) begin
                row           = m_t[i] / hh[i] - 1;
                m_table[i][row] = m_f[i][row];
                m_rv[i]       = 1'b1;
                m_ridx[i]     = row;
                m_rz[i]       = m_f[i][row];
            end
            if (m_t[i] == len) begin
                m_phase[i] = 2;
                m_pass[i]  = (m_table[i] == ee[i]);
            end else begin
                m_invec[i] = m_t[i] / hh[i];
            end
        end else begin
            m_phase[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, if_a.start);
        model_step(1, rst_b, if_b.start);
    end

    task automatic compare(input int i, input string p);
        chk({p, ".busy"},      64'(bsy(i)), 64'(m_phase[i] == 1));
        chk({p, ".done"},      64'(dn(i)),  64'(m_phase[i] == 2));
        chk({p, ".row_valid"}, 64'(rv(i)),  64'(m_rv[i]));
        chk({p, ".row_idx"},   ridx(i),     64'(m_ridx[i]));
        chk({p, ".row_z"},     64'(rz(i)),  64'(m_rz[i]));
        chk({p, ".table_out"}, tab(i),      m_table[i]);
        chk({p, ".pass"},      64'(pas(i)), 64'(m_pass[i]));
        chk({p, ".in_vec"},    ivec(i),     64'(m_invec[i]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            compare(0, "a");
            compare(1, "b");
        end
    end

    // One sweep on instance i. pre_started: edge S already happened.
    // leave_start: value of start during the first IDLE cycle after done.
    task automatic sweep(input int i, input bit spam, input bit pre_started, input bit leave_start,
                         output int cyc, output int nrv, output logic [63:0] zs,
                         output int ndone, output bit busy_ok, output int done_idx);
        cyc = 0; nrv = 0; zs = '0; ndone = 0; busy_ok = 1'b1; done_idx = -1;
        if (!pre_started) begin
            @(negedge clk); set_start(i, 1'b1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 300 && ndone == 0; k++) begin
            @(negedge clk); set_start(i, spam);
            @(posedge clk); #1;
            cyc++;
            if (rv(i)) begin
                nrv++;
                zs[ridx(i)] = rz(i);
            end
            if (dn(i)) begin
                ndone++;
                if (rv(i)) done_idx = int'(ridx(i));
            end else if (!bsy(i)) begin
                busy_ok = 1'b0;
            end
        end
        chk("sweep_done_seen", 64'(ndone), 64'd1);
        @(negedge clk); set_start(i, spam);
        @(posedge clk); #1;
        if (dn(i)) ndone++;
        if (bsy(i)) busy_ok = 1'b0;
        @(negedge clk); set_start(i, leave_start);
    endtask

    initial begin
        int          cyc, nrv, ndone, didx;
        logic [63:0] zs;
        bit          bok;

        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy",  64'(bsy(0)), 64'd0);
        chk("reset.table", tab(0),      64'd0);
        chk("reset.done",  64'(dn(1)),  64'd0);
        chk("reset.pass",  64'(pas(1)), 64'd0);
        @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;

        // Reference expression: only row 0 (x=0,y=0) yields 1; done visible after edge S+16
        mode[0] = 0;
        sweep(0, 1'b0, 1'b0, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t1.cycles_to_done", 64'(cyc), 64'd16);
        chk("t1.row_valid_count", 64'(nrv), 64'd4);
        chk("t1.row_z_seq", zs, 64'h1);
        chk("t1.table", tab(0), 64'h1);
        chk("t1.pass", 64'(pas(0)), 64'd1);

        mode[0] = 1;
        sweep(0, 1'b0, 1'b0, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t2.table", tab(0), 64'h6);
        chk("t2.pass", 64'(pas(0)), 64'd0);

        mode[0] = 0;
        sweep(0, 1'b1, 1'b0, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t3.done_pulses", 64'(ndone), 64'd1);
        chk("t3.busy_until_done", 64'(bok), 64'd1);
        chk("t3.cycles_to_done", 64'(cyc), 64'd16);

        // Reset in the middle of row 1
        @(negedge clk); set_start(0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); set_start(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4.in_vec_before_reset", ivec(0), 64'd1);
        @(negedge clk); rst_a = 1'b1;
        @(posedge clk); #1;
        chk("t4.busy", 64'(bsy(0)), 64'd0);
        chk("t4.table", tab(0), 64'd0);
        chk("t4.in_vec", ivec(0), 64'd0);
        chk("t4.row_valid", 64'(rv(0)), 64'd0);
        @(negedge clk); rst_a = 1'b0;
        sweep(0, 1'b0, 1'b0, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t4.clean_table", tab(0), 64'h1);
        chk("t4.clean_pass", 64'(pas(0)), 64'd1);

        // AND3, HOLD=1: eight back-to-back row pulses
        mode[1] = 2;
        sweep(1, 1'b0, 1'b0, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t5.cycles_to_done", 64'(cyc), 64'd8);
        chk("t5.row_valid_count", 64'(nrv), 64'd8);
        chk("t5.row_z_seq", zs, 64'h80);
        chk("t5.table", tab(1), 64'h80);
        chk("t5.pass", 64'(pas(1)), 64'd1);
        chk("t5.done_row_idx", 64'(didx), 64'd7);

        // Back-to-back: start held in the first IDLE cycle after done
        sweep(0, 1'b0, 1'b0, 1'b1, cyc, nrv, zs, ndone, bok, didx);
        chk("t6.first_pass", 64'(pas(0)), 64'd1);
        @(posedge clk); #1;
        chk("t6.busy_at_restart", 64'(bsy(0)), 64'd1);
        chk("t6.table_cleared", tab(0), 64'd0);
        chk("t6.pass_cleared", 64'(pas(0)), 64'd0);
        sweep(0, 1'b0, 1'b1, 1'b0, cyc, nrv, zs, ndone, bok, didx);
        chk("t6.second_table", tab(0), 64'h1);

        // Random start/reset traffic with random functions, changed only while idle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] == 0 && $urandom_range(0, 3) == 0) begin
                    mode[i] = int'($urandom_range(0, 3));
                    rtab[i] = {$urandom, $urandom};
                end
                set_start(i, $urandom_range(0, 3) == 0);
                set_rst(i, $urandom_range(0, 79) == 0);
            end
        end
        @(negedge clk);
        set_start(0, 1'b0); set_start(1, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
